// File: rtl/mul_seq_ctrl.sv
// Microcommand sequencer for a shift-and-add multiplier datapath.
// Ports: clk, rst_n (sync, active-low), start, p[3:0] conditions in;
//        clkout (~clk), y[11:0] microcommand, busy, done out.
module mul_seq_ctrl #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  p,
  output logic        clkout,
  output logic [11:0] y,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [11:0] Y_LOAD  = 12'h003;
  localparam logic [11:0] Y_ZERO  = 12'h022;
  localparam logic [11:0] Y_ADD   = 12'h004;
  localparam logic [11:0] Y_SHIFT = 12'h008;
  localparam logic [11:0] Y_SIGN  = 12'h020;
  localparam logic [11:0] Y_SGN   = 12'h010;
  localparam logic [11:0] Y_DONE  = 12'h800;

  typedef enum logic [3:0] {
    IDLE, LOAD, CHECK, ZERO, TEST,
    ADD, SHIFT, SIGN, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign clkout = ~clk;

  // Outputs are registered: each branch loads the
  // microcommand of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      y     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      y    <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            y     <= Y_LOAD;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          cnt   <= CNT_N;
          state <= CHECK;
        end
        CHECK: begin
          if (p[1] | p[2]) begin
            state <= ZERO;
            y     <= Y_ZERO;
          end else begin
            state <= TEST;
          end
        end
        ZERO: begin
          state <= DONE;
          y     <= Y_DONE;
          done  <= 1'b1;
        end
        TEST: begin
          if (p[0]) begin
            state <= ADD;
            y     <= Y_ADD;
          end else begin
            state <= SHIFT;
            y     <= Y_SHIFT;
          end
        end
        ADD: begin
          state <= SHIFT;
          y     <= Y_SHIFT;
        end
        SHIFT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            // Operand signs are stable for the whole run,
            // so the sign flag is captured on entry to SIGN
            // to keep y glitch-free.
            state <= SIGN;
            y     <= Y_SIGN | (p[3] ? Y_SGN : 12'h000);
          end else begin
            state <= TEST;
          end
        end
        SIGN: begin
          state <= DONE;
          y     <= Y_DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl (N=8).
// Small datapath stand-in feeds p from the bench operands.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  p;
  logic        clkout;
  logic [11:0] y;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [7:0] b_ld = 8'h00;
  logic [7:0] b_sh = 8'h00;
  logic       a_zero = 1'b0;
  logic       b_zero = 1'b0;
  logic       sgn = 1'b0;

  mul_seq_ctrl #(.N(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .p      (p),
    .clkout (clkout),
    .y      (y),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Multiplier register: loads on LOAD, shifts on SHIFT
  // (datapath acts on clkout rising, i.e. clk falling).
  always @(negedge clk) begin
    if (y == 12'h003) b_sh <= b_ld;
    else if (y == 12'h008) b_sh <= b_sh >> 1;
  end

  assign p = {sgn, b_zero, a_zero, b_sh[0]};

  task automatic run_op(input string nm,
                        input logic [7:0] b,
                        input logic az,
                        input logic bz,
                        input logic s,
                        input bit hold,
                        input int exp_done);
    logic [11:0] q[$];
    int dc;
    int idle_c;
    logic eb;
    logic ed;
    q.push_back(12'h003);
    q.push_back(12'h000);
    if (az | bz) begin
      q.push_back(12'h022);
    end else begin
      for (int i = 0; i < 8; i++) begin
        q.push_back(12'h000);
        if (b[i]) q.push_back(12'h004);
        q.push_back(12'h008);
      end
      q.push_back(s ? 12'h030 : 12'h020);
    end
    q.push_back(12'h800);
    q.push_back(12'h000);
    idle_c = q.size();
    if (hold) q.push_back(12'h003);
    b_ld = b; a_zero = az; b_zero = bz; sgn = s;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    dc = -1;
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      eb = (c != idle_c);
      ed = (q[c-1] == 12'h800);
      checks++;
      if (y !== q[c-1] || busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL %s cycle %0d: y=%h busy=%b done=%b, want y=%h busy=%b done=%b",
                 nm, c, y, busy, done, q[c-1], eb, ed);
      end
      if (done === 1'b1 && dc < 0) dc = c;
    end
    checks++;
    if (dc !== exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", nm, dc, exp_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (clkout !== 1'b0) begin
        errors++;
        $display("FAIL reset_clkout_hi: clkout=%b want 0", clkout);
      end
      @(negedge clk);
      checks++;
      if (y !== 12'h000 || busy !== 1'b0 || done !== 1'b0 || clkout !== 1'b1) begin
        errors++;
        $display("FAIL reset_outs: y=%h busy=%b done=%b clkout=%b want 000 0 0 1",
                 y, busy, done, clkout);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (y !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: y=%h busy=%b done=%b want 000 0 0",
                 y, busy, done);
      end
    end
  endtask

  task automatic test_normal;
    run_op("normal_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 24);
  endtask

  task automatic test_zero;
    run_op("zero_a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    run_op("zero_b", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4);
  endtask

  task automatic test_sign_ff;
    run_op("sign_ff", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 28);
    run_op("all_zero_bits", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 20);
  endtask

  task automatic test_reset_mid;
    int shifts;
    bit hit;
    shifts = 0;
    hit = 0;
    b_ld = 8'hA5; a_zero = 0; b_zero = 0; sgn = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (y == 12'h008) shifts++;
      if (shifts == 5) begin
        hit = 1;
        rst_n = 1'b0;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_shift5: fifth SHIFT not seen in 40 cycles");
    end
    @(negedge clk);
    checks++;
    if (y !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: y=%h busy=%b done=%b want 000 0 0",
               y, busy, done);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || y !== 12'h000) begin
        errors++;
        $display("FAIL reset_mid_quiet: y=%h busy=%b done=%b want 000 0 0",
                 y, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_op("hold_1st", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 22);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (y !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cleanup: y=%h busy=%b want 000 0", y, busy);
    end
  endtask

  task automatic test_clkout;
    for (int i = 0; i < 6; i++) begin
      rst_n = (i % 3 != 1);
      @(posedge clk);
      #1;
      checks++;
      if (clkout !== ~clk) begin
        errors++;
        $display("FAIL clkout_rise: clkout=%b clk=%b", clkout, clk);
      end
      @(negedge clk);
      #1;
      checks++;
      if (clkout !== ~clk) begin
        errors++;
        $display("FAIL clkout_fall: clkout=%b clk=%b", clkout, clk);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_normal;
    test_zero;
    test_sign_ff;
    test_reset_mid;
    test_back_to_back;
    test_clkout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
